// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter between NUM_MASTERS core-side memory
// requesters and the single ram port. One transaction is in flight at a
// time. Its address, data and mask are latched at grant so the ram side
// stays stable even if the master changes or drops its inputs.
//
// Ports:
//   clk, rst           clock (rising edge) and async active-low reset
//   m_ren_i/m_raddr_i  per-master read request and address (packed, k*ADDR_W)
//   m_wen_i/m_waddr_i/m_wdata_i/m_wmask_i  per-master write request and payload
//   m_rdata_o          shared read data, valid with an m_rvalid_o bit
//   m_rvalid_o         one-hot, one-cycle read completion pulse
//   m_wdone_o          one-hot, one-cycle write completion pulse
//   m_busy_o           one-hot, high while that master owns the grant
//   ram_ren_o/ram_raddr_o/ram_rready_i/ram_rdata_i          ram read channel
//   ram_wen_o/ram_waddr_o/ram_wdata_o/ram_wmask_o/
//   ram_wready_i/ram_bvalid_i                               ram write channel
module mem_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_MASTERS-1:0]        m_ren_i,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_raddr_i,
  input  logic [NUM_MASTERS-1:0]        m_wen_i,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_waddr_i,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata_i,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wmask_i,
  output logic [DATA_W-1:0]             m_rdata_o,
  output logic [NUM_MASTERS-1:0]        m_rvalid_o,
  output logic [NUM_MASTERS-1:0]        m_wdone_o,
  output logic [NUM_MASTERS-1:0]        m_busy_o,
  output logic                          ram_ren_o,
  output logic [ADDR_W-1:0]             ram_raddr_o,
  input  logic                          ram_rready_i,
  input  logic [DATA_W-1:0]             ram_rdata_i,
  output logic                          ram_wen_o,
  output logic [ADDR_W-1:0]             ram_waddr_o,
  output logic [DATA_W-1:0]             ram_wdata_o,
  output logic [DATA_W-1:0]             ram_wmask_o,
  input  logic                          ram_wready_i,
  input  logic                          ram_bvalid_i
);

  localparam int PTR_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_WRESP, S_DONE} state_e;

  state_e                   state_q,  state_d;
  logic [PTR_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]         grant_q,  grant_d;
  logic [DATA_W-1:0]        rdata_q,  rdata_d;
  logic [ADDR_W-1:0]        raddr_q,  raddr_d;
  logic [ADDR_W-1:0]        waddr_q,  waddr_d;
  logic [DATA_W-1:0]        wdata_q,  wdata_d;
  logic [DATA_W-1:0]        wmask_q,  wmask_d;
  logic                     ren_q,    ren_d;
  logic                     wen_q,    wen_d;
  logic [NUM_MASTERS-1:0]   rvalid_q, rvalid_d;
  logic [NUM_MASTERS-1:0]   wdone_q,  wdone_d;
  logic [NUM_MASTERS-1:0]   busy_q,   busy_d;

  logic [NUM_MASTERS-1:0]   req;
  logic                     found;
  logic [PTR_W-1:0]         pick;
  logic [PTR_W:0]           cand_w;
  logic [PTR_W-1:0]         cand;

  logic [ADDR_W-1:0] raddr_arr [NUM_MASTERS];
  logic [ADDR_W-1:0] waddr_arr [NUM_MASTERS];
  logic [DATA_W-1:0] wdata_arr [NUM_MASTERS];
  logic [DATA_W-1:0] wmask_arr [NUM_MASTERS];

  for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_unpack
    assign raddr_arr[k] = m_raddr_i[k*ADDR_W +: ADDR_W];
    assign waddr_arr[k] = m_waddr_i[k*ADDR_W +: ADDR_W];
    assign wdata_arr[k] = m_wdata_i[k*DATA_W +: DATA_W];
    assign wmask_arr[k] = m_wmask_i[k*DATA_W +: DATA_W];
  end

  assign req = m_ren_i | m_wen_i;

  // Round-robin search: first requester at or after rr_ptr, wrapping.
  // NOTE: every variable driven in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    found  = 1'b0;
    pick   = '0;
    cand_w = '0;
    cand   = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      cand_w = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
      if (cand_w >= (PTR_W+1)'(NUM_MASTERS)) begin
        cand_w = cand_w - (PTR_W+1)'(NUM_MASTERS);
      end
      cand = cand_w[PTR_W-1:0];
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    rdata_d  = rdata_q;
    raddr_d  = raddr_q;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    wmask_d  = wmask_q;
    ren_d    = ren_q;
    wen_d    = wen_q;
    rvalid_d = '0;      // completion pulses live for the DONE cycle only
    wdone_d  = '0;
    busy_d   = busy_q;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d      = pick;
          busy_d       = '0;
          busy_d[pick] = 1'b1;
          // A write beats a read from the same master; the read stays
          // pending and is picked up at that master's next turn.
          if (m_wen_i[pick]) begin
            waddr_d = waddr_arr[pick];
            wdata_d = wdata_arr[pick];
            wmask_d = wmask_arr[pick];
            wen_d   = 1'b1;
            state_d = S_WR;
          end else begin
            raddr_d = raddr_arr[pick];
            ren_d   = 1'b1;
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        if (ram_rready_i) begin
          rdata_d           = ram_rdata_i;
          ren_d             = 1'b0;
          rvalid_d[grant_q] = 1'b1;
          state_d           = S_DONE;
        end
      end
      S_WR: begin
        if (ram_wready_i) begin
          wen_d = 1'b0;
          if (ram_bvalid_i) begin
            wdone_d[grant_q] = 1'b1;
            state_d          = S_DONE;
          end else begin
            state_d = S_WRESP;
          end
        end
      end
      S_WRESP: begin
        if (ram_bvalid_i) begin
          wdone_d[grant_q] = 1'b1;
          state_d          = S_DONE;
        end
      end
      S_DONE: begin
        busy_d   = '0;
        rr_ptr_d = (grant_q == PTR_W'(NUM_MASTERS-1)) ? '0 : grant_q + 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      rdata_q  <= '0;
      raddr_q  <= '0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      wmask_q  <= '0;
      ren_q    <= 1'b0;
      wen_q    <= 1'b0;
      rvalid_q <= '0;
      wdone_q  <= '0;
      busy_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      rdata_q  <= rdata_d;
      raddr_q  <= raddr_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      wmask_q  <= wmask_d;
      ren_q    <= ren_d;
      wen_q    <= wen_d;
      rvalid_q <= rvalid_d;
      wdone_q  <= wdone_d;
      busy_q   <= busy_d;
    end
  end

  assign m_rdata_o   = rdata_q;
  assign m_rvalid_o  = rvalid_q;
  assign m_wdone_o   = wdone_q;
  assign m_busy_o    = busy_q;
  assign ram_ren_o   = ren_q;
  assign ram_raddr_o = raddr_q;
  assign ram_wen_o   = wen_q;
  assign ram_waddr_o = waddr_q;
  assign ram_wdata_o = wdata_q;
  assign ram_wmask_o = wmask_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios for mem_arbiter (4 masters) followed by
// randomized rounds. In the random rounds a ram stub with random latencies
// answers the ram port from its own memory, and a transaction-level model
// (round-robin over pending ops, write-before-read per master, masked memory
// updates) predicts the completion order and every read value.
module tb_mem_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    m_ren_i, m_wen_i;
  logic [N*AW-1:0] m_raddr_i, m_waddr_i;
  logic [N*DW-1:0] m_wdata_i, m_wmask_i;
  logic [DW-1:0]   m_rdata_o;
  logic [N-1:0]    m_rvalid_o, m_wdone_o, m_busy_o;
  logic            ram_ren_o, ram_wen_o;
  logic [AW-1:0]   ram_raddr_o, ram_waddr_o;
  logic            ram_rready_i, ram_wready_i, ram_bvalid_i;
  logic [DW-1:0]   ram_rdata_i, ram_wdata_o, ram_wmask_o;

  mem_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .m_ren_i(m_ren_i), .m_raddr_i(m_raddr_i),
    .m_wen_i(m_wen_i), .m_waddr_i(m_waddr_i),
    .m_wdata_i(m_wdata_i), .m_wmask_i(m_wmask_i),
    .m_rdata_o(m_rdata_o), .m_rvalid_o(m_rvalid_o),
    .m_wdone_o(m_wdone_o), .m_busy_o(m_busy_o),
    .ram_ren_o(ram_ren_o), .ram_raddr_o(ram_raddr_o),
    .ram_rready_i(ram_rready_i), .ram_rdata_i(ram_rdata_i),
    .ram_wen_o(ram_wen_o), .ram_waddr_o(ram_waddr_o),
    .ram_wdata_o(ram_wdata_o), .ram_wmask_o(ram_wmask_o),
    .ram_wready_i(ram_wready_i), .ram_bvalid_i(ram_bvalid_i)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_data"}, {ram_wdata_o, m_rdata_o}, '0);
    check({tag, "_addr"}, {ram_wmask_o, ram_raddr_o, ram_waddr_o}, '0);
    check({tag, "_ctrl"}, {m_rvalid_o, m_wdone_o, m_busy_o, ram_ren_o, ram_wen_o}, '0);
  endtask

  // ---------------- memories: ram stub and reference model ----------------
  logic [DW-1:0] stub_mem [logic [AW-1:0]];
  logic [DW-1:0] mdl_mem  [logic [AW-1:0]];

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return {a ^ 32'h5A5A_0000, ~a};
  endfunction

  function automatic logic [DW-1:0] stub_rd(input logic [AW-1:0] a);
    return stub_mem.exists(a) ? stub_mem[a] : init_val(a);
  endfunction

  function automatic logic [DW-1:0] mdl_rd(input logic [AW-1:0] a);
    return mdl_mem.exists(a) ? mdl_mem[a] : init_val(a);
  endfunction

  // ram stub state
  bit rd_active, w_active, awaiting;
  int rd_cnt, rd_dly, w_cnt, w_dly, b_cnt, b_dly;

  // Called once per negedge: answers the ram port with random latencies and
  // toggles response lines the arbiter must ignore when nothing is pending.
  task automatic stub_step();
    ram_rready_i = 1'b0;
    ram_wready_i = 1'b0;
    ram_bvalid_i = 1'b0;
    ram_rdata_i  = {$urandom, $urandom};
    if (ram_ren_o) begin
      if (!rd_active) begin rd_active = 1; rd_cnt = 0; rd_dly = $urandom_range(0, 2); end
      if (rd_cnt == rd_dly) begin
        ram_rready_i = 1'b1;
        ram_rdata_i  = stub_rd(ram_raddr_o);
        rd_active    = 0;
      end else rd_cnt++;
    end else begin
      ram_rready_i = ($urandom_range(0, 3) == 0);
    end
    if (ram_wen_o) begin
      if (!w_active) begin w_active = 1; w_cnt = 0; w_dly = $urandom_range(0, 2); end
      if (w_cnt == w_dly) begin
        ram_wready_i = 1'b1;
        stub_mem[ram_waddr_o] = (stub_rd(ram_waddr_o) & ~ram_wmask_o) | (ram_wdata_o & ram_wmask_o);
        w_active = 0;
        if ($urandom_range(0, 1) == 1) ram_bvalid_i = 1'b1;
        else begin awaiting = 1; b_cnt = 0; b_dly = $urandom_range(0, 2); end
      end else begin
        w_cnt++;
        ram_bvalid_i = ($urandom_range(0, 3) == 0);
      end
    end else if (awaiting) begin
      if (b_cnt == b_dly) begin ram_bvalid_i = 1'b1; awaiting = 0; end
      else b_cnt++;
      ram_wready_i = ($urandom_range(0, 3) == 0);
    end else begin
      ram_wready_i = ($urandom_range(0, 3) == 0);
      ram_bvalid_i = ($urandom_range(0, 3) == 0);
    end
  endtask

  // ---------------- random-round bookkeeping ----------------
  typedef struct {
    int            m;
    bit            w;
    logic [DW-1:0] d;
  } ev_t;

  ev_t           exp_q[$];
  ev_t           ev;
  logic [N-1:0]  pr, pw, pr2, pw2, oh;
  logic [AW-1:0] ra [N];
  logic [AW-1:0] wa [N];
  logic [DW-1:0] wd [N];
  logic [DW-1:0] wm [N];
  logic [AW-1:0] fa [N];
  logic [DW-1:0] old_v;
  int            mdl_ptr, ptr, fk, cyc, n_pulse, last_cyc, first_cyc, op;

  initial begin
    rst = 1'b1;
    m_ren_i = '0; m_wen_i = '0;
    m_raddr_i = '0; m_waddr_i = '0; m_wdata_i = '0; m_wmask_i = '0;
    ram_rready_i = 1'b0; ram_wready_i = 1'b0; ram_bvalid_i = 1'b0; ram_rdata_i = '0;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b1;

    // ---- single read, M0, ram answers 2 cycles after ren ----
    @(negedge clk);
    m_ren_i[0] = 1'b1;
    m_raddr_i[0 +: AW] = 32'h8000_0010;
    @(negedge clk);
    check("t1_ren", ram_ren_o, 1);
    check("t1_raddr", ram_raddr_o, 32'h8000_0010);
    check("t1_busy", m_busy_o, 4'b0001);
    check("t1_rvalid_early", m_rvalid_o, 0);
    m_raddr_i[0 +: AW] = 32'h1234_5678;
    @(negedge clk);
    check("t1_raddr_held", ram_raddr_o, 32'h8000_0010);
    check("t1_ren_held", ram_ren_o, 1);
    @(negedge clk);
    check("t1_rvalid_wait", m_rvalid_o, 0);
    ram_rready_i = 1'b1;
    ram_rdata_i  = 64'hDEADBEEF_CAFEF00D;
    @(negedge clk);
    check("t1_rvalid", m_rvalid_o, 4'b0001);
    check("t1_rdata", m_rdata_o, 64'hDEADBEEF_CAFEF00D);
    check("t1_ren_drop", ram_ren_o, 0);
    check("t1_busy_done", m_busy_o, 4'b0001);
    ram_rready_i = 1'b0;
    ram_rdata_i  = 64'h0BAD_0BAD_0BAD_0BAD;
    m_ren_i[0]   = 1'b0;
    @(negedge clk);
    check("t1_rvalid_clear", m_rvalid_o, 0);
    check("t1_busy_clear", m_busy_o, 0);
    check("t1_rdata_hold", m_rdata_o, 64'hDEADBEEF_CAFEF00D);

    // ---- split write, M1: wready at cycle 3, bvalid at cycle 5 ----
    m_wen_i[1] = 1'b1;
    m_waddr_i[1*AW +: AW] = 32'h8000_0100;
    m_wdata_i[1*DW +: DW] = 64'h1122334455667788;
    m_wmask_i[1*DW +: DW] = 64'h00000000FFFFFFFF;
    @(negedge clk);
    check("t2_wen", ram_wen_o, 1);
    check("t2_ren", ram_ren_o, 0);
    check("t2_waddr", ram_waddr_o, 32'h8000_0100);
    check("t2_wdata", ram_wdata_o, 64'h1122334455667788);
    check("t2_wmask", ram_wmask_o, 64'h00000000FFFFFFFF);
    check("t2_busy", m_busy_o, 4'b0010);
    m_wen_i[1] = 1'b0;                       // dropped while granted
    m_wdata_i[1*DW +: DW] = ~64'h1122334455667788;
    m_wmask_i[1*DW +: DW] = '1;
    ram_bvalid_i = 1'b1;                     // without wready: ignored
    @(negedge clk);
    check("t2_wen_held", ram_wen_o, 1);
    check("t2_wdata_held", ram_wdata_o, 64'h1122334455667788);
    check("t2_wdone_early", m_wdone_o, 0);
    ram_bvalid_i = 1'b0;
    @(negedge clk);
    check("t2_wmask_held", ram_wmask_o, 64'h00000000FFFFFFFF);
    check("t2_wen_held2", ram_wen_o, 1);
    ram_wready_i = 1'b1;
    @(negedge clk);
    check("t2_wen_drop", ram_wen_o, 0);
    check("t2_wdone_wresp", m_wdone_o, 0);
    check("t2_busy_wresp", m_busy_o, 4'b0010);
    ram_wready_i = 1'b0;
    @(negedge clk);
    check("t2_wdone_wresp2", m_wdone_o, 0);
    ram_bvalid_i = 1'b1;
    @(negedge clk);
    check("t2_wdone", m_wdone_o, 4'b0010);
    ram_bvalid_i = 1'b0;
    @(negedge clk);
    check("t2_wdone_once", m_wdone_o, 0);
    check("t2_busy_clear", m_busy_o, 0);

    // ---- same-master read+write, M0; wready+bvalid together ----
    m_ren_i[0] = 1'b1; m_wen_i[0] = 1'b1;
    m_raddr_i[0 +: AW] = 32'h8000_0200;
    m_waddr_i[0 +: AW] = 32'h8000_0300;
    m_wdata_i[0 +: DW] = 64'hA5A5_5A5A_0F0F_F0F0;
    m_wmask_i[0 +: DW] = '1;
    @(negedge clk);
    check("t3_wen_first", ram_wen_o, 1);
    check("t3_ren_pending", ram_ren_o, 0);
    check("t3_waddr", ram_waddr_o, 32'h8000_0300);
    check("t3_busy", m_busy_o, 4'b0001);
    ram_wready_i = 1'b1; ram_bvalid_i = 1'b1;
    @(negedge clk);
    check("t5_wdone_2cyc", m_wdone_o, 4'b0001);
    check("t3_rvalid_none", m_rvalid_o, 0);
    ram_wready_i = 1'b0; ram_bvalid_i = 1'b0;
    m_wen_i[0] = 1'b0;
    @(negedge clk);
    check("t3_wdone_clear", m_wdone_o, 0);
    check("t3_idle_ren", ram_ren_o, 0);
    @(negedge clk);
    check("t3_read_ren", ram_ren_o, 1);
    check("t3_read_raddr", ram_raddr_o, 32'h8000_0200);
    check("t3_read_busy", m_busy_o, 4'b0001);
    ram_rready_i = 1'b1;
    ram_rdata_i  = 64'h0123_4567_89AB_CDEF;
    @(negedge clk);
    check("t3_rvalid", m_rvalid_o, 4'b0001);
    check("t3_rdata", m_rdata_o, 64'h0123_4567_89AB_CDEF);
    ram_rready_i = 1'b0;
    m_ren_i[0] = 1'b0;
    @(negedge clk);
    check("t3_rvalid_clear", m_rvalid_o, 0);

    // ---- reset in the middle of a read ----
    m_ren_i[2] = 1'b1;
    m_raddr_i[2*AW +: AW] = 32'h8000_0400;
    @(negedge clk);
    check("t6_ren", ram_ren_o, 1);
    check("t6_busy", m_busy_o, 4'b0100);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check_zero("t6_async");
    m_ren_i[2] = 1'b0;
    @(negedge clk);
    check_zero("t6_held");
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("t6_no_stale", {m_rvalid_o, m_wdone_o, m_busy_o, ram_ren_o, ram_wen_o}, 0);
    end

    // ---- fairness: all four read continuously, ram answers at once ----
    for (int k = 0; k < N; k++) begin
      fa[k] = 32'h8000_1000 + 32'(k * 8);
      m_raddr_i[k*AW +: AW] = fa[k];
    end
    m_ren_i = '1;
    n_pulse = 0; last_cyc = 0; first_cyc = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (m_rvalid_o != 0 && n_pulse < 5) begin
        oh = N'(1) << (n_pulse % N);
        check("fair_grant", m_rvalid_o, oh);
        check("fair_rdata", m_rdata_o, {~fa[n_pulse % N], fa[n_pulse % N]});
        if (n_pulse > 0) check("fair_gap", c - last_cyc, 3);
        else first_cyc = c;
        last_cyc = c;
        n_pulse++;
        if (n_pulse == 5) m_ren_i = '0;
      end
      ram_rready_i = ram_ren_o;
      ram_rdata_i  = {~ram_raddr_o, ram_raddr_o};
    end
    check("fair_count", n_pulse, 5);
    check("fair_first_latency", first_cyc, 2);

    // ---- randomized rounds against the transaction model ----
    ram_rready_i = 1'b0; ram_wready_i = 1'b0; ram_bvalid_i = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    mdl_ptr = 0;
    rd_active = 0; w_active = 0; awaiting = 0;
    for (int r = 0; r < 40; r++) begin
      for (int k = 0; k < N; k++) begin
        op    = $urandom_range(0, 3);
        pr[k] = op[0];
        pw[k] = op[1];
        ra[k] = 32'h8000_0000 + 32'($urandom_range(0, 7) * 8);
        wa[k] = 32'h8000_0000 + 32'($urandom_range(0, 7) * 8);
        wd[k] = {$urandom, $urandom};
        wm[k] = {$urandom, $urandom};
      end
      // Expected completion order: round-robin over pending ops, a master's
      // write before its read; memory effects applied in that order.
      pr2 = pr; pw2 = pw; ptr = mdl_ptr;
      while ((pr2 | pw2) != 0) begin
        fk = -1;
        for (int i = 0; i < N; i++)
          if (fk < 0 && (pr2[(ptr + i) % N] || pw2[(ptr + i) % N])) fk = (ptr + i) % N;
        ev.m = fk;
        if (pw2[fk]) begin
          ev.w = 1;
          old_v = mdl_rd(wa[fk]);
          mdl_mem[wa[fk]] = (old_v & ~wm[fk]) | (wd[fk] & wm[fk]);
          ev.d = '0;
          pw2[fk] = 1'b0;
        end else begin
          ev.w = 0;
          ev.d = mdl_rd(ra[fk]);
          pr2[fk] = 1'b0;
        end
        exp_q.push_back(ev);
        ptr = (fk + 1) % N;
      end
      mdl_ptr = ptr;

      for (int k = 0; k < N; k++) begin
        m_raddr_i[k*AW +: AW] = ra[k];
        m_waddr_i[k*AW +: AW] = wa[k];
        m_wdata_i[k*DW +: DW] = wd[k];
        m_wmask_i[k*DW +: DW] = wm[k];
      end
      m_ren_i = pr;
      m_wen_i = pw;
      cyc = 0;
      while (exp_q.size() > 0 && cyc < 300) begin
        @(negedge clk);
        cyc++;
        if (m_rvalid_o != 0 || m_wdone_o != 0) begin
          ev = exp_q.pop_front();
          oh = N'(1) << ev.m;
          check("rnd_pulse", {m_wdone_o, m_rvalid_o}, ev.w ? {oh, {N{1'b0}}} : {{N{1'b0}}, oh});
          check("rnd_busy", m_busy_o, oh);
          if (!ev.w) check("rnd_rdata", m_rdata_o, ev.d);
          if (ev.w) m_wen_i[ev.m] = 1'b0;
          else      m_ren_i[ev.m] = 1'b0;
        end
        stub_step();
      end
      check("rnd_drain", exp_q.size(), 0);
      exp_q.delete();
      m_ren_i = '0; m_wen_i = '0;
      @(negedge clk);
      check("rnd_idle", {m_rvalid_o, m_wdone_o, m_busy_o}, 0);
      stub_step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
